// File: rtl/mux_41.sv
// 4:1 word multiplexer with a combinational output and a registered copy.
// out follows d[sel] with zero latency and ignores clk and rst_n.
// out_q and sel_q capture the selection on each rising clk edge.
module mux_41 #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d0,
  input  logic [WIDTH-1:0] d1,
  input  logic [WIDTH-1:0] d2,
  input  logic [WIDTH-1:0] d3,
  input  logic [1:0]       sel,
  output logic [WIDTH-1:0] out,
  output logic [WIDTH-1:0] out_q,
  output logic [1:0]       sel_q
);

  // Steer the selected word onto out. An unknown select deliberately
  // yields all-X so that a bad select is visible instead of being masked.
  always_comb begin
    out = '0;
    case (sel)
      2'b00:   out = d0;
      2'b01:   out = d1;
      2'b10:   out = d2;
      2'b11:   out = d3;
      default: out = {WIDTH{1'bx}};
    endcase
  end

  // Registered copy of the selected word and its select. Reset clears both
  // immediately and holds them while rst_n is low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q <= '0;
      sel_q <= 2'b00;
    end else begin
      out_q <= out;
      sel_q <= sel;
    end
  end

endmodule

// File: tb/tb_mux_41.sv
// Self-checking bench for mux_41: directed scenarios plus randomized
// traffic compared with an array-indexed reference model.
module tb_mux_41;

  localparam int WIDTH = 32;

  logic             clk;
  logic             rst_n;
  logic [WIDTH-1:0] dv [4];
  logic [1:0]       sel;
  logic [WIDTH-1:0] out;
  logic [WIDTH-1:0] out_q;
  logic [1:0]       sel_q;

  int asserts;
  int fails;

  // Reference state for the registered outputs.
  logic [WIDTH-1:0] exp_q;
  logic [1:0]       exp_sel_q;

  logic [WIDTH-1:0] pat [4];

  mux_41 #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .d0    (dv[0]),
    .d1    (dv[1]),
    .d2    (dv[2]),
    .d3    (dv[3]),
    .sel   (sel),
    .out   (out),
    .out_q (out_q),
    .sel_q (sel_q)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Safety net: the run must never hang.
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  // Reference model: the selected word is simply the array element.
  function automatic logic [WIDTH-1:0] model_word(input logic [1:0] s);
    return dv[s];
  endfunction

  // Advance one rising edge, updating the model with the values present
  // at the edge, and return 1 time unit after it.
  task automatic edge_step();
    if (rst_n) begin
      exp_q     = model_word(sel);
      exp_sel_q = sel;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic load_patterns();
    for (int i = 0; i < 4; i++) dv[i] = pat[i];
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    load_patterns();
    sel = 2'b00;
    #1;
    asserts++;
    if (out_q !== '0) begin
      fails++;
      $display("FAIL reset_out_q: got %h expected %h", out_q, {WIDTH{1'b0}});
    end
    asserts++;
    if (sel_q !== 2'b00) begin
      fails++;
      $display("FAIL reset_sel_q: got %b expected 00", sel_q);
    end
    asserts++;
    if (out !== pat[0]) begin
      fails++;
      $display("FAIL reset_out_tracks: got %h expected %h", out, pat[0]);
    end
    @(posedge clk);
    #1;
    asserts++;
    if (out_q !== '0 || sel_q !== 2'b00) begin
      fails++;
      $display("FAIL reset_held: got out_q=%h sel_q=%b expected 0/00", out_q, sel_q);
    end
    exp_q     = '0;
    exp_sel_q = 2'b00;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_comb_map();
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      sel = 2'(i);
      #1;
      asserts++;
      if (out !== pat[i]) begin
        fails++;
        $display("FAIL comb_map sel=%0d: got %h expected %h", i, out, pat[i]);
      end
    end
  endtask

  task automatic test_registered();
    @(negedge clk);
    sel = 2'b11;
    edge_step();
    @(negedge clk);
    sel = 2'b10;
    #1;
    asserts++;
    if (out_q !== pat[3]) begin
      fails++;
      $display("FAIL reg_hold_before_edge: got %h expected %h", out_q, pat[3]);
    end
    edge_step();
    asserts++;
    if (out_q !== pat[2] || out_q !== exp_q) begin
      fails++;
      $display("FAIL reg_capture_out_q: got %h expected %h", out_q, pat[2]);
    end
    asserts++;
    if (sel_q !== 2'b10) begin
      fails++;
      $display("FAIL reg_capture_sel_q: got %b expected 10", sel_q);
    end
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    sel = 2'b11;
    #2;
    rst_n = 1'b0;
    #1;
    asserts++;
    if (out_q !== '0 || sel_q !== 2'b00) begin
      fails++;
      $display("FAIL async_reset_clear: got out_q=%h sel_q=%b expected 0/00", out_q, sel_q);
    end
    asserts++;
    if (out !== pat[3]) begin
      fails++;
      $display("FAIL async_reset_out: got %h expected %h", out, pat[3]);
    end
    exp_q     = '0;
    exp_sel_q = 2'b00;
    edge_step();
    asserts++;
    if (out_q !== '0 || sel_q !== 2'b00 || out !== pat[3]) begin
      fails++;
      $display("FAIL async_reset_hold: got out_q=%h sel_q=%b out=%h expected 0/00/%h",
               out_q, sel_q, out, pat[3]);
    end
    @(negedge clk);
    rst_n = 1'b1;
    edge_step();
    asserts++;
    if (out_q !== pat[3] || sel_q !== 2'b11) begin
      fails++;
      $display("FAIL first_edge_after_reset: got out_q=%h sel_q=%b expected %h/11",
               out_q, sel_q, pat[3]);
    end
  endtask

  task automatic test_comb_update();
    @(negedge clk);
    sel = 2'b01;
    edge_step();
    @(negedge clk);
    #1;
    dv[1] = 32'h1234_5678;
    #1;
    asserts++;
    if (out !== 32'h1234_5678) begin
      fails++;
      $display("FAIL comb_update_out: got %h expected 12345678", out);
    end
    asserts++;
    if (out_q !== pat[1]) begin
      fails++;
      $display("FAIL comb_update_out_q_hold: got %h expected %h", out_q, pat[1]);
    end
    edge_step();
    asserts++;
    if (out_q !== 32'h1234_5678) begin
      fails++;
      $display("FAIL comb_update_out_q_edge: got %h expected 12345678", out_q);
    end
    load_patterns();
  endtask

  task automatic test_x_select();
    logic probe;
    probe = 1'bx;
    @(negedge clk);
    sel = 2'bx0;
    #1;
    // Only meaningful on a four-state simulator.
    if (probe === 1'bx) begin
      asserts++;
      if (out !== {WIDTH{1'bx}}) begin
        fails++;
        $display("FAIL x_select_out: got %h expected all-X", out);
      end
    end
    sel = 2'b00;
    #1;
    asserts++;
    if (out !== pat[0]) begin
      fails++;
      $display("FAIL x_select_restore: got %h expected %h", out, pat[0]);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      sel = 2'(3 - (i % 4));
      edge_step();
      asserts++;
      if (out_q !== pat[3 - (i % 4)] || sel_q !== 2'(3 - (i % 4))) begin
        fails++;
        $display("FAIL back_to_back cycle %0d: got out_q=%h sel_q=%b expected %h/%b",
                 i, out_q, sel_q, pat[3 - (i % 4)], 2'(3 - (i % 4)));
      end
    end
  endtask

  task automatic test_random();
    logic [1:0] s;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      for (int k = 0; k < 4; k++) dv[k] = $urandom;
      s   = 2'($urandom_range(0, 3));
      sel = s;
      #1;
      asserts++;
      if (out !== model_word(s)) begin
        fails++;
        $display("FAIL random_comb iter %0d: got %h expected %h", i, out, model_word(s));
      end
      if ($urandom_range(0, 15) == 0) begin
        #1;
        rst_n = 1'b0;
        exp_q     = '0;
        exp_sel_q = 2'b00;
        #1;
        asserts++;
        if (out_q !== '0 || sel_q !== 2'b00) begin
          fails++;
          $display("FAIL random_reset iter %0d: got out_q=%h sel_q=%b expected 0/00",
                   i, out_q, sel_q);
        end
        rst_n = 1'b1;
      end
      edge_step();
      asserts++;
      if (out_q !== exp_q || sel_q !== exp_sel_q) begin
        fails++;
        $display("FAIL random_reg iter %0d: got out_q=%h sel_q=%b expected %h/%b",
                 i, out_q, sel_q, exp_q, exp_sel_q);
      end
    end
  endtask

  initial begin
    asserts = 0;
    fails   = 0;
    pat[0] = 32'hAAAA_AAAA;
    pat[1] = 32'hBBBB_BBBB;
    pat[2] = 32'hCCCC_CCCC;
    pat[3] = 32'hDDDD_DDDD;
    test_reset();
    test_comb_map();
    test_registered();
    test_async_reset();
    test_comb_update();
    test_x_select();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
    $finish;
  end

endmodule
